bcd_tick_timer: RTL and testbench

- MM:SS stopwatch/timer fed by the slow square wave from the 50 MHz frequency divider.
- Synchronises that wave into the clk_50mhz domain and edge-detects it; everything runs on clk_50mhz, never on the divided clock.
- Each detected rising edge advances or retreats a 4-digit BCD count.
- Digits drive four 7-segment displays directly (HEX0..HEX3 on the board).

---
 rtl/bcd_tick_timer.sv | 155 +++++++++++++++
 tb/tb_bcd_tick_timer.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/bcd_tick_timer.sv
// MM:SS BCD stopwatch advanced by rising edges of an external divided square wave.
// All logic runs on clk_50mhz; tick_in and start_stop are synchronised and edge-detected.
module bcd_tick_timer #(
    parameter int MAX_MIN        = 59,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk_50mhz,
    input  logic       rst,
    input  logic       tick_in,
    input  logic       start_stop,
    input  logic       clear,
    input  logic       dir,
    output logic [3:0] sec_ones,
    output logic [3:0] sec_tens,
    output logic [3:0] min_ones,
    output logic [3:0] min_tens,
    output logic [6:0] hex0,
    output logic [6:0] hex1,
    output logic [6:0] hex2,
    output logic [6:0] hex3,
    output logic       running,
    output logic       wrap_pulse
);
    localparam logic [3:0] MAX_T   = 4'(MAX_MIN / 10);
    localparam logic [3:0] MAX_O   = 4'(MAX_MIN % 10);
    localparam logic [6:0] SEG_INV = SEG_ACTIVE_LOW ? 7'h00 : 7'h7f;

    typedef enum logic {STOPPED = 1'b0, RUN = 1'b1} state_t;

    state_t     state_q, state_d;
    logic [2:0] tick_sync, ss_sync;
    logic       tick_rise, ss_rise, count_en, wrap_d;
    logic [3:0] n_so, n_st, n_mo, n_mt;

    always_ff @(posedge clk_50mhz or negedge rst) begin
        if (!rst) begin
            tick_sync <= 3'b000;
            ss_sync   <= 3'b000;
        end else begin
            tick_sync <= {tick_sync[1:0], tick_in};
            ss_sync   <= {ss_sync[1:0], start_stop};
        end
    end

    assign tick_rise = tick_sync[1] & ~tick_sync[2];
    assign ss_rise   = ss_sync[1] & ~ss_sync[2];
    // Tick is qualified by the pre-toggle state, so a coincident ss_rise does not affect it.
    assign count_en  = (state_q == RUN) && tick_rise && !clear;

    always_ff @(posedge clk_50mhz or negedge rst) begin
        if (!rst) state_q <= STOPPED;
        else      state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (clear)        state_d = STOPPED;
        else if (ss_rise) state_d = (state_q == RUN) ? STOPPED : RUN;
    end

    assign running = (state_q == RUN);

    always_comb begin
        n_so   = sec_ones;
        n_st   = sec_tens;
        n_mo   = min_ones;
        n_mt   = min_tens;
        wrap_d = 1'b0;
        if (!dir) begin
            if (sec_ones != 4'd9) n_so = sec_ones + 4'd1;
            else begin
                n_so = 4'd0;
                if (sec_tens != 4'd5) n_st = sec_tens + 4'd1;
                else begin
                    n_st = 4'd0;
                    if (min_tens == MAX_T && min_ones == MAX_O) begin
                        n_mo   = 4'd0;
                        n_mt   = 4'd0;
                        wrap_d = 1'b1;
                    end else if (min_ones != 4'd9) n_mo = min_ones + 4'd1;
                    else begin
                        n_mo = 4'd0;
                        n_mt = min_tens + 4'd1;
                    end
                end
            end
        end else begin
            if (sec_ones != 4'd0) n_so = sec_ones - 4'd1;
            else begin
                n_so = 4'd9;
                if (sec_tens != 4'd0) n_st = sec_tens - 4'd1;
                else begin
                    n_st = 4'd5;
                    if (min_tens == 4'd0 && min_ones == 4'd0) begin
                        n_mo   = MAX_O;
                        n_mt   = MAX_T;
                        wrap_d = 1'b1;
                    end else if (min_ones != 4'd0) n_mo = min_ones - 4'd1;
                    else begin
                        n_mo = 4'd9;
                        n_mt = min_tens - 4'd1;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk_50mhz or negedge rst) begin
        if (!rst) begin
            sec_ones   <= 4'd0;
            sec_tens   <= 4'd0;
            min_ones   <= 4'd0;
            min_tens   <= 4'd0;
            wrap_pulse <= 1'b0;
        end else if (clear) begin
            sec_ones   <= 4'd0;
            sec_tens   <= 4'd0;
            min_ones   <= 4'd0;
            min_tens   <= 4'd0;
            wrap_pulse <= 1'b0;
        end else begin
            wrap_pulse <= count_en & wrap_d;
            if (count_en) begin
                sec_ones <= n_so;
                sec_tens <= n_st;
                min_ones <= n_mo;
                min_tens <= n_mt;
            end
        end
    end

    // Active-low table; out-of-range digits blank the display.
    function automatic logic [6:0] seg7(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b1111111;
        endcase
        return s ^ SEG_INV;
    endfunction

    assign hex0 = seg7(sec_ones);
    assign hex1 = seg7(sec_tens);
    assign hex2 = seg7(min_ones);
    assign hex3 = seg7(min_tens);
endmodule

// File: tb/tb_bcd_tick_timer.sv
// Directed bench for bcd_tick_timer: a default instance plus a MAX_MIN=9 active-high
// instance sharing the same stimulus.
module tb_bcd_tick_timer;
    logic       clk_50mhz = 1'b0;
    logic       rst = 1'b0;
    logic       tick_in = 1'b0, start_stop = 1'b0, clear = 1'b0, dir = 1'b0;
    logic [3:0] so, st, mo, mt, so2, st2, mo2, mt2;
    logic [6:0] h0, h1, h2, h3, g0, g1, g2, g3;
    logic       running, wrap_pulse, running2, wrap2;
    int         checks = 0, failures = 0;

    always #10 clk_50mhz = ~clk_50mhz;

    bcd_tick_timer dut (
        .clk_50mhz(clk_50mhz), .rst(rst), .tick_in(tick_in), .start_stop(start_stop),
        .clear(clear), .dir(dir), .sec_ones(so), .sec_tens(st), .min_ones(mo), .min_tens(mt),
        .hex0(h0), .hex1(h1), .hex2(h2), .hex3(h3), .running(running), .wrap_pulse(wrap_pulse)
    );

    bcd_tick_timer #(.MAX_MIN(9), .SEG_ACTIVE_LOW(1'b0)) dut9 (
        .clk_50mhz(clk_50mhz), .rst(rst), .tick_in(tick_in), .start_stop(start_stop),
        .clear(clear), .dir(dir), .sec_ones(so2), .sec_tens(st2), .min_ones(mo2), .min_tens(mt2),
        .hex0(g0), .hex1(g1), .hex2(g2), .hex3(g3), .running(running2), .wrap_pulse(wrap2)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk_50mhz);
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            tick_in = 1'b1; clks(4);
            tick_in = 1'b0; clks(4);
        end
    endtask

    task automatic press();
        start_stop = 1'b1; clks(4);
        start_stop = 1'b0; clks(4);
    endtask

    // Packs MM:SS as 16'hMMSS for compact checks.
    function automatic logic [15:0] t1();
        return {mt, mo, st, so};
    endfunction
    function automatic logic [15:0] t2();
        return {mt2, mo2, st2, so2};
    endfunction

    initial begin
        #15;
        chk("reset_time", {16'h0, t1()}, 32'h0);
        chk("reset_hex", {4'h0, h3, h2, h1, h0}, {4'h0, {4{7'b1000000}}});
        chk("reset_run_wrap", {running, wrap_pulse}, 2'b00);
        chk("reset_hex_ah", {25'h0, g0}, 32'h3f);
        clks(2);
        rst = 1'b1;
        clks(2);

        press();
        chk("start_running", running, 1'b1);

        // Latency: driven at a negedge, update lands on the 3rd following posedge.
        tick_in = 1'b1;
        repeat (2) @(posedge clk_50mhz);
        @(negedge clk_50mhz);
        chk("lat_edge2", so, 4'd0);
        @(posedge clk_50mhz);
        @(negedge clk_50mhz);
        chk("lat_edge3", so, 4'd1);
        tick_in = 1'b0; clks(4);
        chk("fall_no_effect", so, 4'd1);
        tick(2);
        chk("three_ticks", t1(), 16'h0003);
        chk("hex0_three", h0, 7'b0110000);

        tick(56);
        chk("t_0059", t1(), 16'h0059);
        tick(1);
        chk("t_0100", t1(), 16'h0100);
        chk("hex2_one", h2, 7'b1111001);
        tick(3539);
        chk("t_5959", t1(), 16'h5959);
        chk("t9_0959", t2(), 16'h0959);

        tick_in = 1'b1;
        repeat (3) @(posedge clk_50mhz);
        @(negedge clk_50mhz);
        chk("up_wrap_time", t1(), 16'h0000);
        chk("up_wrap_pulse", wrap_pulse, 1'b1);
        chk("t9_up_wrap", {t2(), 15'h0, wrap2}, 32'h00000001);
        @(negedge clk_50mhz);
        chk("up_wrap_one_cycle", wrap_pulse, 1'b0);
        tick_in = 1'b0; clks(4);

        dir = 1'b1;
        tick_in = 1'b1;
        repeat (3) @(posedge clk_50mhz);
        @(negedge clk_50mhz);
        chk("dn_wrap_time", t1(), 16'h5959);
        chk("dn_wrap_pulse", wrap_pulse, 1'b1);
        chk("t9_dn_wrap", {t2(), 15'h0, wrap2}, 32'h09590001);
        @(negedge clk_50mhz);
        chk("dn_wrap_one_cycle", wrap_pulse, 1'b0);
        tick_in = 1'b0; clks(4);
        dir = 1'b0;
        tick(1);
        chk("dir_back_up", t1(), 16'h0000);

        // Clear coincident with a tick_rise.
        clear = 1'b1; clks(1); clear = 1'b0; clks(1);
        chk("clear_stops", running, 1'b0);
        press();
        tick(7);
        chk("t_0007", t1(), 16'h0007);
        tick_in = 1'b1;
        repeat (2) @(posedge clk_50mhz);
        @(negedge clk_50mhz);
        clear = 1'b1;
        @(negedge clk_50mhz);
        chk("clr_tick_time", t1(), 16'h0000);
        chk("clr_tick_run_wrap", {running, wrap_pulse}, 2'b00);
        clear = 1'b0;
        tick_in = 1'b0; clks(4);
        tick(2);
        chk("stopped_discard", t1(), 16'h0000);

        // Coincident tick and start_stop edges.
        press();
        tick(5);
        press();
        chk("t_0005_stopped", {t1(), 15'h0, running}, 32'h00050000);
        tick_in = 1'b1; start_stop = 1'b1; clks(4);
        tick_in = 1'b0; start_stop = 1'b0; clks(4);
        chk("coinc_from_stop", {t1(), 15'h0, running}, 32'h00050001);
        tick_in = 1'b1; start_stop = 1'b1; clks(4);
        tick_in = 1'b0; start_stop = 1'b0; clks(4);
        chk("coinc_from_run", {t1(), 15'h0, running}, 32'h00060000);

        // Async reset mid-count.
        press();
        tick(748);
        chk("t_1234", t1(), 16'h1234);
        chk("hex3_one", h3, 7'b1111001);
        @(posedge clk_50mhz);
        #3 rst = 1'b0;
        #1;
        chk("async_rst_time", t1(), 16'h0000);
        chk("async_rst_hex", {4'h0, h3, h2, h1, h0}, {4'h0, {4{7'b1000000}}});
        chk("async_rst_running", running, 1'b0);
        clks(2);
        rst = 1'b1;
        clks(2);
        tick(1);
        chk("after_rst_stopped", t1(), 16'h0000);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
